contador_varredura: RTL and testbench

Display scan controller for the coffee-machine front panel. It divides the system clock into a scan tick and steps a 2-bit digit index through 0..3. That index drives the select inputs (`saida1Contador`, `saida2Contador`) of the per-message 7-segment decoders, such as the ESN error decoder. The same index also drives the active-low digit anodes. It latches error events and blinks the error message until the operator acknowledges it.

---
 rtl/painel_pkg.sv | 20 ++
 rtl/divisor_tick.sv | 42 ++++
 rtl/contador_varredura.sv | 103 ++++++++++
 tb/tb_contador_varredura.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/painel_pkg.sv
// Shared constants and helpers for the coffee-machine front panel.
// Digit count, blank anode pattern and the active-low one-hot anode encoder.
package painel_pkg;

    localparam int N_DIGITOS = 4;

    localparam logic [N_DIGITOS-1:0] ANODOS_APAGADOS = 4'b1111;

    typedef logic [1:0] digito_t;

    // Active-low one-hot: bit idx is 0, all others 1.
    function automatic logic [N_DIGITOS-1:0] anodo_ativo(
        input digito_t idx
    );
        logic [N_DIGITOS-1:0] um;
        um = N_DIGITOS'(1);
        return ~(um << idx);
    endfunction

endpackage

// File: rtl/divisor_tick.sv
// Prescaler: counts 0..DIVISOR-1 while habilita=1 and flags the last count.
// Ports: clock, reset_n (async, active-low), habilita (low = hold), tick (out).
module divisor_tick #(
    parameter int DIVISOR = 50000
) (
    input  logic clock,
    input  logic reset_n,
    input  logic habilita,
    output logic tick
);

    localparam int W = $clog2(DIVISOR);
    localparam logic [W-1:0] TOPO = W'(DIVISOR - 1);
    localparam logic [W-1:0] UM   = W'(1);

    logic [W-1:0] pre;
    logic [W-1:0] pre_d;

    // Combinational so the pulse lines up with pre==TOPO in the same cycle;
    // gating with habilita keeps it quiet while frozen.
    assign tick = habilita && (pre == TOPO);

    always_comb begin
        pre_d = pre;
        if (habilita) begin
            if (pre == TOPO) begin
                pre_d = '0;
            end else begin
                pre_d = pre + UM;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pre <= '0;
        end else begin
            pre <= pre_d;
        end
    end

endmodule

// File: rtl/contador_varredura.sv
// Display scan controller: steps the digit index on each scan tick, drives
// the active-low anodes and blinks the display while an error is latched.
// Ports: clock, reset_n, habilita, erro, reconhece in; saida1Contador,
// saida2Contador (index MSB/LSB), anodos[3:0], msg_erro, tick out.
module contador_varredura
    import painel_pkg::*;
#(
    parameter int DIVISOR     = 50000,
    parameter int PISCA_TICKS = 250
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       habilita,
    input  logic       erro,
    input  logic       reconhece,
    output logic       saida1Contador,
    output logic       saida2Contador,
    output logic [3:0] anodos,
    output logic       msg_erro,
    output logic       tick
);

    localparam int PW = (PISCA_TICKS > 1) ? $clog2(PISCA_TICKS) : 1;
    localparam logic [PW-1:0] PC_MAX = PW'(PISCA_TICKS - 1);
    localparam logic [PW-1:0] PC_UM  = PW'(1);

    digito_t     dig;
    digito_t     dig_d;
    logic        msg_d;
    logic        visivel;
    logic        visivel_d;
    logic [PW-1:0] pc;
    logic [PW-1:0] pc_d;
    logic [3:0]  anodos_d;

    divisor_tick #(
        .DIVISOR (DIVISOR)
    ) u_div (
        .clock    (clock),
        .reset_n  (reset_n),
        .habilita (habilita),
        .tick     (tick)
    );

    assign saida1Contador = dig[1];
    assign saida2Contador = dig[0];

    always_comb begin
        dig_d = dig;
        if (tick) begin
            dig_d = dig + 2'd1;
        end
    end

    // Set dominates acknowledge.
    always_comb begin
        msg_d = erro | (msg_erro & ~reconhece);
    end

    // Blink phase. A fresh error restarts visible with a full half-period;
    // a cleared latch forces the display back on.
    always_comb begin
        pc_d      = pc;
        visivel_d = visivel;
        if (!msg_d || !msg_erro) begin
            pc_d      = '0;
            visivel_d = 1'b1;
        end else if (tick) begin
            if (pc == PC_MAX) begin
                pc_d      = '0;
                visivel_d = ~visivel;
            end else begin
                pc_d = pc + PC_UM;
            end
        end
    end

    // Anodes are computed from the next index so they switch on the same
    // edge as the decoder select lines.
    always_comb begin
        anodos_d = ANODOS_APAGADOS;
        if (habilita && visivel_d) begin
            anodos_d = anodo_ativo(dig_d);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            dig      <= '0;
            msg_erro <= 1'b0;
            visivel  <= 1'b1;
            pc       <= '0;
            anodos   <= ANODOS_APAGADOS;
        end else begin
            dig      <= dig_d;
            msg_erro <= msg_d;
            visivel  <= visivel_d;
            pc       <= pc_d;
            anodos   <= anodos_d;
        end
    end

endmodule

// File: tb/tb_contador_varredura.sv
// Directed bench for contador_varredura with DIVISOR=4, PISCA_TICKS=2.
// Scan, freeze, blink, acknowledge and async-reset scenarios.
module tb_contador_varredura;

    logic       clock;
    logic       reset_n;
    logic       habilita;
    logic       erro;
    logic       reconhece;
    logic       saida1Contador;
    logic       saida2Contador;
    logic [3:0] anodos;
    logic       msg_erro;
    logic       tick;

    int total = 0;
    int bad   = 0;

    logic [3:0] an_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    contador_varredura #(
        .DIVISOR     (4),
        .PISCA_TICKS (2)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .habilita       (habilita),
        .erro           (erro),
        .reconhece      (reconhece),
        .saida1Contador (saida1Contador),
        .saida2Contador (saida2Contador),
        .anodos         (anodos),
        .msg_erro       (msg_erro),
        .tick           (tick)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [1:0] dig_obs();
        return {saida1Contador, saida2Contador};
    endfunction

    // 16 edges from a fresh reset with habilita=1.
    task automatic scan16(input string tag);
        logic [1:0] d;
        for (int i = 1; i <= 16; i++) begin
            step();
            d = 2'((i / 4) % 4);
            chk($sformatf("%s_dig%0d", tag, i), 8'(dig_obs()), 8'(d));
            chk($sformatf("%s_tick%0d", tag, i), 8'(tick),
                8'((i % 4) == 3));
            chk($sformatf("%s_an%0d", tag, i), 8'(anodos), 8'(an_tab[d]));
        end
    endtask

    initial begin
        logic [1:0] d;
        logic       vis;
        reset_n   = 1'b0;
        habilita  = 1'b0;
        erro      = 1'b0;
        reconhece = 1'b0;

        @(negedge clock);
        chk("rst_an", 8'(anodos), 8'hF);
        chk("rst_dig", 8'(dig_obs()), 8'h0);
        chk("rst_msg", 8'(msg_erro), 8'h0);
        chk("rst_tick", 8'(tick), 8'h0);

        @(negedge clock);
        reset_n  = 1'b1;
        habilita = 1'b1;
        scan16("scan");

        // Freeze at pre=2, dig=0.
        step();
        step();
        chk("pre2_dig", 8'(dig_obs()), 8'h0);
        habilita = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            step();
            chk($sformatf("frz_an%0d", i), 8'(anodos), 8'hF);
            chk($sformatf("frz_dig%0d", i), 8'(dig_obs()), 8'h0);
            chk($sformatf("frz_tick%0d", i), 8'(tick), 8'h0);
        end
        habilita = 1'b1;
        step();
        chk("res_tick1", 8'(tick), 8'h1);
        chk("res_an1", 8'(anodos), 8'hE);
        chk("res_dig1", 8'(dig_obs()), 8'h0);
        step();
        chk("res_tick2", 8'(tick), 8'h0);
        chk("res_dig2", 8'(dig_obs()), 8'h1);
        chk("res_an2", 8'(anodos), 8'hD);

        // Error sampled on a tick-ending edge.
        step();
        step();
        step();
        chk("pre_err_tick", 8'(tick), 8'h1);
        erro = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            step();
            if (k == 1) erro = 1'b0;
            d   = 2'((2 + (k - 1) / 4) % 4);
            vis = (((k - 1) / 8) % 2) == 0;
            chk($sformatf("blk_msg%0d", k), 8'(msg_erro), 8'h1);
            chk($sformatf("blk_dig%0d", k), 8'(dig_obs()), 8'(d));
            chk($sformatf("blk_an%0d", k), 8'(anodos),
                vis ? 8'(an_tab[d]) : 8'hF);
        end

        // Set wins over acknowledge; edge 25 is a tick edge into blank.
        erro      = 1'b1;
        reconhece = 1'b1;
        step();
        chk("both_msg", 8'(msg_erro), 8'h1);
        chk("both_an", 8'(anodos), 8'hF);
        chk("both_dig", 8'(dig_obs()), 8'h0);
        erro = 1'b0;
        step();
        reconhece = 1'b0;
        chk("ack_msg", 8'(msg_erro), 8'h0);
        chk("ack_an", 8'(anodos), 8'hE);

        // New error, run to dig=2 in the blank phase.
        erro = 1'b1;
        step();
        erro = 1'b0;
        chk("err2_msg", 8'(msg_erro), 8'h1);
        chk("err2_an", 8'(anodos), 8'hE);
        for (int i = 0; i < 6; i++) step();
        chk("mid_dig", 8'(dig_obs()), 8'h2);
        chk("mid_msg", 8'(msg_erro), 8'h1);
        chk("mid_an", 8'(anodos), 8'hF);

        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_dig", 8'(dig_obs()), 8'h0);
        chk("arst_msg", 8'(msg_erro), 8'h0);
        chk("arst_an", 8'(anodos), 8'hF);
        chk("arst_tick", 8'(tick), 8'h0);

        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        scan16("rescan");
        chk("rescan_msg", 8'(msg_erro), 8'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
